// File: rtl/sc_pkg.sv
// sc_pkg: shared stochastic-computing constants and helpers.
//   SC_N      value width; a stream holds 2^SC_N bits
//   SC_W      bits delivered per stream word
//   SC_K      words per stream
//   sc_cnt_w  width of a counter over k words (minimum 1 bit)
package sc_pkg;
    localparam int SC_N = 6;
    localparam int SC_W = 32;
    localparam int SC_K = (1 << SC_N) / SC_W;
    function automatic int sc_cnt_w(input int k);
        return (k <= 1) ? 1 : $clog2(k);
    endfunction
endpackage

// File: rtl/sc_popcnt.sv
// sc_popcnt: combinational W-bit ones-counter built as a recursive adder tree.
//   i_bits  in  W              input word
//   o_cnt   out ceil(log2(W+1)) number of ones in i_bits
module sc_popcnt #(
    parameter int W = 32,
    localparam int OW = $clog2(W + 1)
) (
    input  logic [W-1:0]  i_bits,
    output logic [OW-1:0] o_cnt
);
    generate
        if (W == 1) begin : g_leaf
            assign o_cnt = i_bits;
        end else begin : g_split
            localparam int WL = W / 2;
            localparam int WH = W - WL;
            localparam int OL = $clog2(WL + 1);
            localparam int OH = $clog2(WH + 1);
            logic [OL-1:0] w_lo;
            logic [OH-1:0] w_hi;
            sc_popcnt #(.W(WL)) u_lo (.i_bits(i_bits[WL-1:0]), .o_cnt(w_lo));
            sc_popcnt #(.W(WH)) u_hi (.i_bits(i_bits[W-1:WL]), .o_cnt(w_hi));
            assign o_cnt = OW'(w_lo) + OW'(w_hi);
        end
    endgenerate
endmodule

// File: rtl/sc_decoder.sv
// sc_decoder: counts ones over a 2^N-bit unipolar stream delivered as W-bit
// words and emits the saturated N-bit result with a one-cycle valid pulse.
//   clk     in  1  clock, rising edge
//   rst     in  1  asynchronous active-low reset
//   en_in   in  1  seq valid, accepted unconditionally
//   seq     in  W  stream word
//   num     out N  recovered value, held until the next result
//   en_out  out 1  one-cycle result pulse
//   busy    out 1  partial stream in progress
//   sat     out 1  raw count equalled 2^N (only when SC_DEC_SAT_EN is defined)
// Build option: SC_DEC_SAT_EN adds the sat port.
module sc_decoder
    import sc_pkg::*;
#(
    parameter int N = SC_N,
    parameter int W = SC_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_in,
    input  logic [W-1:0] seq,
    output logic [N-1:0] num,
    output logic         en_out,
`ifdef SC_DEC_SAT_EN
    output logic         sat,
`endif
    output logic         busy
);
    localparam int K  = (1 << N) / W;
    localparam int CW = sc_cnt_w(K);
    localparam int PW = $clog2(W + 1);

    logic [PW-1:0] w_pcnt;
    logic [N:0]    w_total;
    logic          w_last;
    logic [CW-1:0] r_wcnt;
    logic [N:0]    r_acc;
    logic [N-1:0]  r_num;
    logic          r_en_out;
    logic          r_busy;
    logic          r_sat;

    sc_popcnt #(.W(W)) u_popcnt (.i_bits(seq), .o_cnt(w_pcnt));

    // acc never exceeds 2^N, so N+1 bits hold the total without wrapping
    assign w_total = r_acc + (N + 1)'(w_pcnt);
    assign w_last  = r_wcnt == CW'(K - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wcnt   <= '0;
            r_acc    <= '0;
            r_num    <= '0;
            r_en_out <= 1'b0;
            r_busy   <= 1'b0;
            r_sat    <= 1'b0;
        end else begin
            r_en_out <= en_in && w_last;
            if (en_in) begin
                r_busy <= !w_last;
                if (w_last) begin
                    // only total = 2^N sets bit N, which saturates to all ones
                    r_num  <= w_total[N] ? '1 : w_total[N-1:0];
                    r_sat  <= w_total[N];
                    r_acc  <= '0;
                    r_wcnt <= '0;
                end else begin
                    r_acc  <= w_total;
                    r_wcnt <= r_wcnt + CW'(1);
                end
            end
        end
    end

    assign num    = r_num;
    assign en_out = r_en_out;
    assign busy   = r_busy;
`ifdef SC_DEC_SAT_EN
    assign sat    = r_sat;
`else
    logic w_unused;
    assign w_unused = r_sat;
`endif
endmodule

// File: tb/tb_sc_decoder.sv
// tb_sc_decoder: directed self-checking bench for sc_decoder (N=6, W=32, K=2).
module tb_sc_decoder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en_in = 1'b0;
    logic [31:0] seq = '0;
    logic [5:0]  num;
    logic        en_out;
    logic        busy;
`ifdef SC_DEC_SAT_EN
    logic        sat;
`endif
    int checks = 0;
    int failures = 0;

    sc_decoder dut (
        .clk(clk), .rst(rst), .en_in(en_in), .seq(seq),
        .num(num), .en_out(en_out),
`ifdef SC_DEC_SAT_EN
        .sat(sat),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic word(input logic [31:0] s);
        en_in = 1'b1;
        seq = s;
        @(posedge clk);
        #1;
        en_in = 1'b0;
        seq = '0;
    endtask

    task automatic idle();
        en_in = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst = 1'b1;
        chk("rst_num", num, 0);
        chk("rst_en_out", en_out, 0);
        chk("rst_busy", busy, 0);
`ifdef SC_DEC_SAT_EN
        chk("rst_sat", sat, 0);
`endif
        idle();
        chk("idle_en_out", en_out, 0);
        chk("idle_busy", busy, 0);

        word(32'h0000_0007);
        chk("s1_busy", busy, 1);
        chk("s1_en_w0", en_out, 0);
        word(32'h0000_FFFF);
        chk("s1_en", en_out, 1);
        chk("s1_num", num, 19);
        chk("s1_busy_end", busy, 0);
        idle();
        chk("s1_en_fall", en_out, 0);
        chk("s1_num_hold", num, 19);

        word(32'hFFFF_FFFF);
        chk("gap_busy0", busy, 1);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("gap_no_pulse", en_out, 0);
            chk("gap_busy", busy, 1);
        end
        word(32'h0000_0000);
        chk("gap_en", en_out, 1);
        chk("gap_num", num, 32);
        chk("gap_busy_end", busy, 0);
        idle();
        chk("gap_en_fall", en_out, 0);

        word(32'hFFFF_FFFF);
        word(32'hFFFF_FFFF);
        chk("sat_en", en_out, 1);
        chk("sat_num", num, 63);
`ifdef SC_DEC_SAT_EN
        chk("sat_flag", sat, 1);
`endif
        word(32'h0000_0001);
        chk("sat_next_en0", en_out, 0);
        word(32'h0000_0000);
        chk("sat_next_en", en_out, 1);
        chk("sat_next_num", num, 1);
`ifdef SC_DEC_SAT_EN
        chk("sat_next_flag", sat, 0);
`endif
        idle();

        word(32'h0000_0003);
        chk("b2b_en_w1", en_out, 0);
        word(32'h0000_0000);
        chk("b2b_en_w2", en_out, 1);
        chk("b2b_num_w2", num, 2);
        word(32'h0000_000F);
        chk("b2b_en_w3", en_out, 0);
        chk("b2b_num_hold", num, 2);
        chk("b2b_busy_w3", busy, 1);
        word(32'h0000_000F);
        chk("b2b_en_w4", en_out, 1);
        chk("b2b_num_w4", num, 8);
        idle();

        word(32'hFFFF_FFFF);
        chk("mrst_busy_pre", busy, 1);
        rst = 1'b0;
        #1;
        chk("mrst_busy_async", busy, 0);
        chk("mrst_num_async", num, 0);
        rst = 1'b1;
        word(32'h0000_0001);
        chk("mrst_en_w0", en_out, 0);
        chk("mrst_busy_w0", busy, 1);
        word(32'h0000_0001);
        chk("mrst_en", en_out, 1);
        chk("mrst_num", num, 2);
        idle();
        chk("mrst_en_fall", en_out, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
